data_memory_responder: RTL and testbench

// - Responder end of the load/store data-memory interface: accepts one request at a time from the load/store units, returns one response per request.
// - Owns a word-addressed data RAM. Performs RV32I sub-word reads with sign/zero extension.
// - Byte/half stores use an internal read-modify-write. Misaligned, out-of-range and illegal-funct3 accesses return an error response.

---
 rtl/rv32_pkg.sv | 72 +++++++
 rtl/data_memory_array.sv | 26 ++
 rtl/data_memory_responder.sv | 155 +++++++++++++++
 tb/tb_data_memory_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the load/store path: funct3 codes, responder
// state encoding and little-endian lane extract/merge helpers.
package rv32_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Select the addressed byte/half of a word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [2:0]  funct3);
        logic [31:0] byte_shift;
        logic [31:0] half_shift;
        logic [7:0]  b;
        logic [15:0] h;
        lane_extract = 32'h0;
        byte_shift   = word >> {addr_lo, 3'b000};
        half_shift   = word >> {addr_lo[1], 4'b0000};
        b            = byte_shift[7:0];
        h            = half_shift[15:0];
        case (funct3)
            F3_LB:   lane_extract = {{24{b[7]}}, b};
            F3_LH:   lane_extract = {{16{h[15]}}, h};
            F3_LW:   lane_extract = word;
            F3_LBU:  lane_extract = {24'h0, b};
            F3_LHU:  lane_extract = {16'h0, h};
            default: lane_extract = 32'h0;
        endcase
    endfunction

    // Replace the addressed byte/half of a word with the low bits of new_data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] new_data,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  funct3);
        logic [31:0] mask;
        logic [31:0] data;
        mask = 32'hFFFF_FFFF;
        data = new_data;
        case (funct3)
            F3_SB: begin
                mask = 32'h0000_00FF << {addr_lo, 3'b000};
                data = {24'h0, new_data[7:0]} << {addr_lo, 3'b000};
            end
            F3_SH: begin
                mask = 32'h0000_FFFF << {addr_lo[1], 4'b0000};
                data = {16'h0, new_data[15:0]} << {addr_lo[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = new_data;
            end
        endcase
        lane_merge = (word & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Single-port DEPTH x 32 data RAM: synchronous read into a registered output,
// synchronous write; contents are never reset.
module data_memory_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             read_enable,
    input  logic             write_enable,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[index] <= write_data;
        end
        if (read_enable) begin
            read_data <= mem[index];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the load/store data-memory interface. One request in
// flight; loads and sub-word stores go through a registered RAM read.
module data_memory_responder
    import rv32_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_write_value,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_read_value,
    output logic        rsp_error,
    output state_t      dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
    // a response transfers with rsp_valid & rsp_ready, rsp_* held stable until then.

    state_t state, state_next;

    logic [31:0]      offset;
    logic             out_of_range;
    logic             misaligned;
    logic             illegal_f3;
    logic             req_err;
    logic             accept;

    logic             write_q;
    logic [1:0]       addr_lo_q;
    logic [2:0]       funct3_q;
    logic [31:0]      wdata_q;
    logic [IDX_W-1:0] index_q;
    logic [31:0]      wbuf;
    logic [31:0]      mem_q;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    always_comb begin
        offset       = req_address - BASE_ADDRESS;
        out_of_range = (req_address < BASE_ADDRESS) ||
                       ({2'b00, offset[31:2]} >= 32'(DEPTH));
        misaligned   = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = (offset[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (req_write) begin
            illegal_f3 = !(req_funct3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegal_f3 = !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
        req_err = out_of_range || misaligned || illegal_f3;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = ST_RESP;
                    end else if (req_write && req_funct3 == F3_SW) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ:  state_next = ST_DATA;
            ST_DATA:  state_next = write_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = rsp_ready ? ST_IDLE : ST_RESP;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid      <= 1'b0;
            rsp_read_value <= 32'h0;
            rsp_error      <= 1'b0;
            write_q        <= 1'b0;
            addr_lo_q      <= 2'b00;
            funct3_q       <= 3'b000;
            wdata_q        <= 32'h0;
            index_q        <= '0;
            wbuf           <= 32'h0;
        end else begin
            rsp_valid <= (state_next == ST_RESP);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        write_q        <= req_write;
                        addr_lo_q      <= offset[1:0];
                        funct3_q       <= req_funct3;
                        wdata_q        <= req_write_value;
                        index_q        <= offset[IDX_W+1:2];
                        wbuf           <= req_write_value;
                        rsp_error      <= req_err;
                        rsp_read_value <= 32'h0;
                    end
                end
                ST_DATA: begin
                    // Loads finish here; sub-word stores merge into the old word.
                    if (write_q) begin
                        wbuf <= lane_merge(mem_q, wdata_q, addr_lo_q, funct3_q);
                    end else begin
                        rsp_read_value <= lane_extract(mem_q, addr_lo_q, funct3_q);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_error      <= 1'b0;
                        rsp_read_value <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    data_memory_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock        (clock),
        .read_enable  (state == ST_READ),
        .write_enable (state == ST_WRITE),
        .index        (index_q),
        .write_data   (wbuf),
        .read_data    (mem_q)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed cases followed by
// randomized traffic against a byte-level reference model.
module tb_data_memory_responder;
    import rv32_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [2:0]  req_funct3;
    logic [31:0] req_write_value;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_read_value;
    logic        rsp_error;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  mb [0:4*DEPTH-1];

    // clock / reset
    always #5 clock = ~clock;

    data_memory_responder #(
        .DEPTH        (DEPTH),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_funct3      (req_funct3),
        .req_write_value (req_write_value),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_read_value  (rsp_read_value),
        .rsp_error       (rsp_error),
        .dbg_state       (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-array reference: size/sign from funct3, value assembled arithmetically.
    function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic err,
                                  output logic [31:0] data, output int lat);
        int     size;
        bit     sgn;
        bit     legal;
        longint v;
        longint off;
        legal = 1;
        sgn   = 0;
        size  = 4;
        if (w) begin
            case (f3)
                3'd0:    size = 1;
                3'd1:    size = 2;
                3'd2:    size = 4;
                default: legal = 0;
            endcase
        end else begin
            case (f3)
                3'd0:    begin size = 1; sgn = 1; end
                3'd1:    begin size = 2; sgn = 1; end
                3'd2:    size = 4;
                3'd4:    size = 1;
                3'd5:    size = 2;
                default: legal = 0;
            endcase
        end
        off  = longint'(a) - longint'(BASE);
        err  = !legal || (off < 0) || (off >= 4 * DEPTH) || ((off % size) != 0);
        data = 32'h0;
        lat  = 1;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < size; i++) mb[int'(off) + i] = wd[8*i +: 8];
                lat = (size == 4) ? 2 : 4;
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(mb[int'(off) + i]) << (8 * i);
                if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
                data = v[31:0];
                lat  = 3;
            end
        end
    endfunction

    // Driver: called at a negedge with the DUT idle; returns at the negedge
    // after the response handshake.
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er);
        logic        e_err;
        logic [31:0] e_data;
        int          e_lat;
        int          lat;
        logic [32:0] exp;
        model(w, a, f3, wd, e_err, e_data, e_lat);
        exp_q.push_back({e_err, e_data});
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid       = 1'b1;
        req_write       = w;
        req_address     = a;
        req_funct3      = f3;
        req_write_value = wd;
        @(posedge clock);
        lat = 0;
        do begin
            @(negedge clock);
            req_valid       = 1'($urandom_range(0, 1));
            req_write       = 1'($urandom_range(0, 1));
            req_address     = $urandom;
            req_funct3      = 3'($urandom_range(0, 7));
            req_write_value = $urandom;
            lat++;
        end while (!rsp_valid && lat < 20);
        check("latency", 32'(lat), 32'(e_lat));
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        rd = rsp_read_value;
        er = rsp_error;
        exp = exp_q.pop_front();
        check("rsp_data", rd, exp[31:0]);
        check("rsp_error", 32'(er), 32'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_read_value, rd);
            check("hold_error", 32'(rsp_error), 32'(er));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_data", rsp_read_value, 32'h0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_ld [5];
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_address     = 32'h0;
        req_funct3      = 3'b000;
        req_write_value = 32'h0;
        rsp_ready       = 1'b0;
        reset           = 1'b1;

        repeat (2) @(negedge clock);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_error", 32'(rsp_error), 32'd0);
        check("rst_data", rsp_read_value, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clock);

        send(1'b1, 32'h10, F3_SW, 32'hDEADBEEF, 0, rd, er);
        check("sw_err", 32'(er), 32'd0);
        send(1'b0, 32'h10, F3_LW, 32'h0, 0, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);
        send(1'b0, 32'h13, F3_LB, 32'h0, 0, rd, er);
        check("lb_13", rd, 32'hFFFFFFDE);
        send(1'b0, 32'h13, F3_LBU, 32'h0, 0, rd, er);
        check("lbu_13", rd, 32'h000000DE);
        send(1'b0, 32'h10, F3_LH, 32'h0, 0, rd, er);
        check("lh_10", rd, 32'hFFFFBEEF);
        send(1'b0, 32'h12, F3_LHU, 32'h0, 0, rd, er);
        check("lhu_12", rd, 32'h0000DEAD);
        send(1'b1, 32'h11, F3_SB, 32'hAAAAAA55, 0, rd, er);
        send(1'b0, 32'h10, F3_LW, 32'h0, 0, rd, er);
        check("lw_after_sb", rd, 32'hDEAD55EF);
        send(1'b1, 32'h12, F3_SH, 32'hBBBB1234, 0, rd, er);
        send(1'b0, 32'h10, F3_LW, 32'h0, 0, rd, er);
        check("lw_after_sh", rd, 32'h123455EF);

        send(1'b0, 32'h11, F3_LW, 32'h0, 0, rd, er);
        check("err_lw_mis", 32'(er), 32'd1);
        send(1'b1, 32'h13, F3_SH, 32'hFFFFFFFF, 0, rd, er);
        check("err_sh_mis", 32'(er), 32'd1);
        send(1'b0, BASE + 32'(4 * DEPTH), F3_LW, 32'h0, 0, rd, er);
        check("err_range", 32'(er), 32'd1);
        send(1'b0, 32'h10, 3'b011, 32'h0, 0, rd, er);
        check("err_f3_ld", 32'(er), 32'd1);
        send(1'b1, 32'h10, 3'b100, 32'h0, 0, rd, er);
        check("err_f3_st", 32'(er), 32'd1);
        send(1'b0, 32'h10, F3_LW, 32'h0, 5, rd, er);
        check("lw_unchanged", rd, 32'h123455EF);

        // Reset while an SB sits in DATA: the merge must never reach the RAM.
        req_valid       = 1'b1;
        req_write       = 1'b1;
        req_address     = 32'h11;
        req_funct3      = F3_SB;
        req_write_value = 32'h00000099;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("sb_state_read", 32'(dbg_state), 32'(ST_READ));
        @(negedge clock);
        check("sb_state_data", 32'(dbg_state), 32'(ST_DATA));
        #1 reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_data", rsp_read_value, 32'h0);
        check("mid_rst_error", 32'(rsp_error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send(1'b0, 32'h10, F3_LW, 32'h0, 0, rd, er);
        check("lw_after_rst", rd, 32'h123455EF);

        for (int i = 0; i < 16; i++) send(1'b1, 32'(4 * i), F3_SW, $urandom, 0, rd, er);

        for (int n = 0; n < 250; n++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                f3 = w ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            case ($urandom_range(0, 19))
                18:      a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
                19:      a = 32'hFFFF0000 | 32'($urandom_range(0, 65535));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            send(w, a, f3, $urandom, $urandom_range(0, 2), rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
